// File: rtl/input_tile_rd_sched.sv
// input_tile_rd_sched: walks F(2x2,3x3) input tiles issuing two row addresses per cycle
module input_tile_rd_sched #(
  parameter int ADDR_W = 8,
  parameter int TROW_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_mode,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [7:0]        cfg_num_rows,
  input  logic              ready_in,
  output logic [ADDR_W-1:0] addr_1_out,
  output logic [ADDR_W-1:0] addr_2_out,
  output logic              addr_1_valid_out,
  output logic              addr_2_valid_out,
  output logic              phase_out,
  output logic [TROW_W-1:0] tile_row_out,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  typedef enum logic [1:0] {IDLE, TOP, BOT, FIN} state_t;
  state_t state_q, state_d;
  logic [TROW_W-1:0] t_q, t_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_1;
  logic [6:0] h_q, h_d;
  logic cfg_err_q, cfg_err_d;
  logic go, legal, act, last, acc;
  always_comb begin
    legal = !cfg_num_rows[0] && cfg_num_rows >= 8'd4;
    go = state_q == IDLE && start && !scan_mode;
    acc = go && legal;
    act = state_q == TOP || state_q == BOT;
    last = t_q + TROW_W'(2) == TROW_W'(h_q);
    state_d = acc ? TOP
      : act && scan_mode ? IDLE
      : state_q == FIN ? IDLE
      : state_q == TOP && ready_in ? BOT
      : state_q == BOT && ready_in ? (last ? FIN : TOP)
      : state_q;
    base_d = acc ? cfg_base : base_q;
    h_d = acc ? cfg_num_rows[7:1] : h_q;
    t_d = acc ? '0 : state_q == BOT && ready_in && !scan_mode && !last ? t_q + TROW_W'(1) : t_q;
    cfg_err_d = go && !legal;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q <= '0;
      base_q <= '0;
      h_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      base_q <= base_d;
      h_q <= h_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign addr_1 = base_q + ADDR_W'({t_q, 1'b0}) + (state_q == BOT ? ADDR_W'(2) : ADDR_W'(0));
  assign addr_1_out = act ? addr_1 : '0;
  assign addr_2_out = act ? addr_1 + ADDR_W'(1) : '0;
  assign addr_1_valid_out = act;
  assign addr_2_valid_out = act;
  assign phase_out = state_q == BOT;
  assign tile_row_out = t_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign cfg_err = cfg_err_q;
endmodule

// File: doc/input_tile_rd_sched.md
# input_tile_rd_sched

Read-address scheduler for the dual-port input data memory. It walks a stored input feature map one 4-row Winograd F(2x2,3x3) input tile at a time, with a vertical stride of 2 rows, and issues two row addresses per cycle, one on each read port. The memory read is combinational, so each address pair and its valids also qualify the data words the memory returns in that same cycle. The block sits between the layer controller (start/config) and the memory's address inputs, and holds off while the memory is being scan-loaded.

## Interface
Parameters:
- ADDR_W, 8, memory line address width; all address arithmetic is modulo 2^ADDR_W.
- TROW_W, 7, width of the tile-row index output.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- scan_mode  in  1  memory scan-load in progress; blocks start and aborts an active run.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- cfg_base  in  ADDR_W  line address of input row 0; latched on start.
- cfg_num_rows  in  8  number of input rows N; latched on start; legal values are even and at least 4.
- ready_in  in  1  downstream tile buffer accepts the current pair.
- addr_1_out  out  ADDR_W  port-1 read address (even row of the pair).
- addr_2_out  out  ADDR_W  port-2 read address (odd row of the pair).
- addr_1_valid_out  out  1  port-1 address valid.
- addr_2_valid_out  out  1  port-2 address valid; always equal to addr_1_valid_out.
- phase_out  out  1  0 = tile rows 0/1, 1 = tile rows 2/3.
- tile_row_out  out  TROW_W  current tile-row index t.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a completed run.
- cfg_err  out  1  one-cycle pulse when a start is rejected for illegal N.

## Operation
- FSM states: IDLE, TOP, BOT, FIN.
- IDLE:
  - start=1, scan_mode=0, and N legal: latch cfg_base and N, set t=0, go to TOP.
  - start=1, scan_mode=0, and N odd or N<4: pulse cfg_err next cycle and stay in IDLE.
  - start while scan_mode=1: ignored.
- Tile count T = (N-2)/2. Tile t covers rows 2t .. 2t+3.
- TOP: valids=1, addr_1=base+2t, addr_2=base+2t+1, phase=0. On handshake (valid && ready_in), go to BOT.
- BOT: valids=1, addr_1=base+2t+2, addr_2=base+2t+3, phase=1. On handshake:
  - t=T-1: go to FIN.
  - otherwise: t=t+1, go to TOP.
- FIN: valids=0, done=1 for exactly this cycle; then go to IDLE.
- Backpressure: while ready_in=0, state, addresses, phase and tile_row_out hold stable. No pair is dropped or repeated.
- Rows shared by adjacent tiles (2t+2, 2t+3) are re-read. There is no row reuse or caching.
- Address wrap: base+offset truncates to ADDR_W bits. 0xFF+1 = 0x00 is legal, not an error.
- start while busy: ignored; the latched config is not modified.
- scan_mode=1 while in TOP/BOT: abort to IDLE on the next edge. Valids are 0 from that edge; no done is produced. A later start restarts from t=0.
- scan_mode=1 while in FIN: FIN completes normally and done still pulses.

## Timing
- Reset (reset=0 at an edge): state=IDLE, t=0. All outputs are 0: addr_1_out=0, addr_2_out=0, both valids=0, phase_out=0, tile_row_out=0, busy=0, done=0, cfg_err=0. Reset wins over every other input and applies mid-run as well.
- Start accepted at edge k: first pair is valid in cycle k+1. There is no bubble between consecutive handshakes.
- With ready_in held at 1: 2T issue cycles followed by 1 FIN cycle. done is high in cycle k+2T+1, and busy drops in cycle k+2T+2.
- A start presented in the same cycle that done is high is ignored. The earliest start that is accepted is in the cycle after FIN.
- cfg_err is high in cycle k+1 for a start rejected at edge k; busy stays 0 throughout.
- All outputs are registered, or are decoded from registered state only. There is no combinational path from ready_in to any output.

## Test plan
- **Basic run:** base=0x10, N=8, ready_in=1 -> pairs in order: (10,11) ph0 t0, (12,13) ph1 t0, (12,13) ph0 t1, (14,15) ph1 t1, (14,15) ph0 t2, (16,17) ph1 t2. done in cycle 7 after the start edge; busy 0 in cycle 8.
- **Backpressure:** same config, ready_in=0 for 3 cycles during the second pair -> (12,13) ph1 held unchanged for 4 cycles. The total sequence is identical to the basic run, and done is delayed by exactly 3 cycles.
- **Illegal N:** N=5, then N=2 -> cfg_err pulses once for each, with no valid and busy=0. A following N=4 start yields (b,b+1), (b+2,b+3), then done.
- **Wrap:** base=0xFE, N=4 -> (FE,FF) ph0, then (00,01) ph1, then done.
- **Scan abort:** scan_mode=1 during tile 1 TOP -> valids 0 on the next edge and no done. start while scan_mode=1 is ignored. After scan_mode=0, a new start replays from (base, base+1).
- **Reset mid-run:** reset=0 during BOT -> all outputs 0 on the next edge. A start is accepted normally after reset returns to 1.
